// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline inter-stage register: payload plus hazard-control fields,
// with stall hold, flush bubble insertion, Tnew countdown and a saturating hold counter.
module pipe_stage_reg #(
    parameter int unsigned DATA_W           = 64,
    parameter int unsigned AW               = 5,
    parameter int unsigned TW               = 2,
    parameter int unsigned EXC_W            = 5,
    parameter int unsigned CNT_W            = 16,
    parameter logic [31:0] RESET_PC         = 32'h0000_3000,
    parameter bit          TNEW_DEC         = 1'b1,
    parameter bit          KEEP_PC_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              flush,
    input  logic              valid_in,
    input  logic              regwrite_in,
    input  logic [AW-1:0]     waddr_in,
    input  logic [TW-1:0]     tnew_in,
    input  logic [31:0]       pc_in,
    input  logic              bd_in,
    input  logic [EXC_W-1:0]  exc_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    output logic              regwrite_out,
    output logic [AW-1:0]     waddr_out,
    output logic [TW-1:0]     tnew_out,
    output logic [31:0]       pc_out,
    output logic              bd_out,
    output logic [EXC_W-1:0]  exc_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  hold_cnt
);

    logic          regwrite_load_c;
    logic [TW-1:0] tnew_load_c;
    logic [CNT_W-1:0] hold_cnt_inc_c;

    // Values captured on a normal load; $0 and bubbles never request a GRF write.
    always_comb begin
        regwrite_load_c = regwrite_in & valid_in & (waddr_in != AW'(0));
        tnew_load_c     = tnew_in;
        if (TNEW_DEC && (tnew_in != TW'(0))) begin
            tnew_load_c = tnew_in - TW'(1);
        end
        hold_cnt_inc_c = hold_cnt;
        if (hold_cnt != {CNT_W{1'b1}}) begin
            hold_cnt_inc_c = hold_cnt + CNT_W'(1);
        end
    end

    // Priority: reset > flush > hold > load. Hold samples no inputs; flush samples only pc/bd.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_out    <= 1'b0;
            regwrite_out <= 1'b0;
            waddr_out    <= '0;
            tnew_out     <= '0;
            pc_out       <= RESET_PC;
            bd_out       <= 1'b0;
            exc_out      <= '0;
            data_out     <= '0;
            hold_cnt     <= '0;
        end else if (flush) begin
            valid_out    <= 1'b0;
            regwrite_out <= 1'b0;
            waddr_out    <= '0;
            tnew_out     <= '0;
            exc_out      <= '0;
            data_out     <= '0;
            if (KEEP_PC_ON_FLUSH) begin
                pc_out <= pc_in;
                bd_out <= bd_in;
            end else begin
                pc_out <= RESET_PC;
                bd_out <= 1'b0;
            end
        end else if (!en) begin
            hold_cnt <= hold_cnt_inc_c;
        end else begin
            valid_out    <= valid_in;
            regwrite_out <= regwrite_load_c;
            waddr_out    <= waddr_in;
            tnew_out     <= tnew_load_c;
            pc_out       <= pc_in;
            bd_out       <= bd_in;
            exc_out      <= exc_in;
            data_out     <= data_in;
        end
    end

endmodule
